// File: rtl/inject_scheduler_if.sv
// -----------------------------------------------------------------------------
// inject_scheduler_if
// Bundles the local-injection handshake and the channel-slot grant signals
// of one bufferless mesh router.
//   ch_busy      : slot occupied by a through flit (0=E, 1=W, 2=N, 3=S)
//   loc_valid    : local flit offered
//   loc_addr     : local flit destination, [5:3]=row, [2:0]=col
//   loc_ready    : local FIFO can accept (push = loc_valid & loc_ready)
//   inj_valid    : head flit injected into a channel slot this cycle
//   inj_grant    : one-hot slot receiving inj_flit
//   inj_flit     : {1'b1, dir[2:0], addr[5:0]}
//   self_deliver : head flit addressed to this router, popped without a slot
//   fifo_count   : entries held in the local FIFO
//   starve       : head flit blocked for too long
// Modports: master = the surrounding router / environment,
//           slave  = the injection scheduler.
// -----------------------------------------------------------------------------
interface inject_scheduler_if #(
  parameter int DEPTH = 4
) ();
  logic [3:0]             ch_busy;
  logic                   loc_valid;
  logic [5:0]             loc_addr;
  logic                   loc_ready;
  logic                   inj_valid;
  logic [3:0]             inj_grant;
  logic [9:0]             inj_flit;
  logic                   self_deliver;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   starve;

  modport master (
    output ch_busy, loc_valid, loc_addr,
    input  loc_ready, inj_valid, inj_grant, inj_flit, self_deliver,
           fifo_count, starve
  );

  modport slave (
    input  ch_busy, loc_valid, loc_addr,
    output loc_ready, inj_valid, inj_grant, inj_flit, self_deliver,
           fifo_count, starve
  );
endinterface

// File: rtl/inject_scheduler.sv
// -----------------------------------------------------------------------------
// inject_scheduler
// Local-injection controller for a bufferless mesh router. Local flits queue
// in a small FIFO, the head flit is XY-routed against this router's
// coordinates, and each cycle the head is given one free output-channel slot,
// chosen round-robin among the free slots. A flit addressed to this router is
// popped as a self-delivery without using a slot.
//
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : inject_scheduler_if.slave (see the interface file for signals)
//
// Parameters: DEPTH (power of two, >= 2), MY_ROW, MY_COL (3-bit coordinates),
//             STARVE_LIMIT (1..255).
// Optional feature: define INJ_STARVE_EN to build the starvation counter;
// without it starve is tied to 0.
// -----------------------------------------------------------------------------
module inject_scheduler #(
  parameter int DEPTH        = 4,
  parameter int MY_ROW       = 4,
  parameter int MY_COL       = 4,
  parameter int STARVE_LIMIT = 15
) (
  input  logic                     clk,
  input  logic                     rst_n,
  inject_scheduler_if.slave        bus
);

  localparam int           AW     = $clog2(DEPTH);
  localparam logic [2:0]   ROW_L  = 3'(MY_ROW);
  localparam logic [2:0]   COL_L  = 3'(MY_COL);
  localparam logic [AW:0]  FULL_L = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    DIR_E     = 3'd0,
    DIR_W     = 3'd1,
    DIR_N     = 3'd2,
    DIR_S     = 3'd3,
    DIR_LOCAL = 3'd4
  } dir_e;

  // Storage and state
  logic [5:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q,  count_d;
  logic [1:0]    rr_ptr_q, rr_ptr_d;

  // Combinational decode
  logic       empty;
  logic       loc_ready;
  logic       push;
  logic       pop;
  logic [5:0] head_addr;
  dir_e       head_dir;
  logic       slot_found;
  logic [1:0] slot_idx;
  logic [1:0] probe;
  logic       inj_valid;
  logic       self_deliver;

  assign empty     = (count_q == '0);
  // Ready is forced low while reset is held so nothing is taken in that cycle.
  assign loc_ready = rst_n && (count_q != FULL_L);
  assign push      = bus.loc_valid && loc_ready;
  assign head_addr = mem_q[rd_ptr_q];

  // XY route: resolve the column first, then the row.
  always_comb begin
    // NOTE: every variable written in an always_comb gets a default first, so
    // no path can leave it unassigned and infer a latch.
    head_dir = DIR_LOCAL;
    if (head_addr[2:0] > COL_L)      head_dir = DIR_E;
    else if (head_addr[2:0] < COL_L) head_dir = DIR_W;
    else if (head_addr[5:3] > ROW_L) head_dir = DIR_N;
    else if (head_addr[5:3] < ROW_L) head_dir = DIR_S;
    else                             head_dir = DIR_LOCAL;
  end

  // Round-robin search over free slots starting at rr_ptr; the 2-bit probe
  // index wraps mod 4 on its own.
  always_comb begin
    slot_found = 1'b0;
    slot_idx   = rr_ptr_q;
    probe      = rr_ptr_q;
    for (int k = 0; k < 4; k++) begin
      probe = rr_ptr_q + 2'(k);
      if (!slot_found && !bus.ch_busy[probe]) begin
        slot_found = 1'b1;
        slot_idx   = probe;
      end
    end
  end

  assign self_deliver = rst_n && !empty && (head_dir == DIR_LOCAL);
  assign inj_valid    = rst_n && !empty && (head_dir != DIR_LOCAL) && slot_found;
  assign pop          = inj_valid || self_deliver;

  // Next-state logic
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    rr_ptr_d = rr_ptr_q;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

    unique case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase

    // The pointer only moves past a slot that was actually granted.
    if (inj_valid) rr_ptr_d = slot_idx + 2'd1;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge value regardless of statement order.
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // NOTE: the FIFO storage has no reset; an entry is only read after it was
  // written, because count/pointers are reset and gate every read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.loc_addr;
  end

`ifdef INJ_STARVE_EN
  localparam logic [7:0] LIMIT_L = 8'(STARVE_LIMIT);

  logic [7:0] starve_cnt_q, starve_cnt_d;

  // Counts cycles in which a queued head could not leave; saturates.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (pop || empty)                 starve_cnt_d = '0;
    else if (starve_cnt_q != LIMIT_L) starve_cnt_d = starve_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) starve_cnt_q <= '0;
    else        starve_cnt_q <= starve_cnt_d;
  end

  assign bus.starve = (starve_cnt_q == LIMIT_L);
`else
  assign bus.starve = 1'b0;
`endif

  // Outputs
  assign bus.loc_ready    = loc_ready;
  assign bus.inj_valid    = inj_valid;
  assign bus.self_deliver = self_deliver;
  assign bus.fifo_count   = count_q;
  assign bus.inj_grant    = inj_valid ? (4'b0001 << slot_idx) : 4'b0000;
  assign bus.inj_flit     = inj_valid ? {1'b1, 3'(head_dir), head_addr} : 10'd0;

endmodule

// File: tb/tb_inject_scheduler.sv
// -----------------------------------------------------------------------------
// tb_inject_scheduler
// Directed bench for inject_scheduler (DEPTH=4, MY_ROW=4, MY_COL=4,
// STARVE_LIMIT=15). Inputs change 1 time unit after a rising edge and outputs
// are compared 1 time unit later, mid-cycle.
// -----------------------------------------------------------------------------
module tb_inject_scheduler;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  inject_scheduler_if #(.DEPTH(4)) bus ();

  inject_scheduler #(
    .DEPTH(4), .MY_ROW(4), .MY_COL(4), .STARVE_LIMIT(15)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Absolute guard: the sequence is linear, so this only trips on a bench bug.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after an input change.
  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.loc_valid = 1'b0;
    bus.loc_addr  = 6'o00;
    bus.ch_busy   = 4'b0000;
    tick();
    rst_n = 1'b1;
  endtask

  localparam logic [9:0] FLIT_57 = 10'b1_000_101111;  // row5 col7 -> E
  localparam logic [9:0] FLIT_14 = 10'b1_011_001100;  // row1 col4 -> S

  initial begin
    total = 0;
    bad   = 0;

    // ---------------- reset ----------------
    rst_n         = 1'b0;
    bus.loc_valid = 1'b1;
    bus.loc_addr  = 6'o57;
    bus.ch_busy   = 4'b0000;
    settle();
    check("rst_loc_ready", 32'(bus.loc_ready), 32'd0);
    check("rst_inj_valid", 32'(bus.inj_valid), 32'd0);
    tick();
    tick();
    bus.loc_valid = 1'b0;
    rst_n         = 1'b1;
    settle();
    check("post_rst_count",     32'(bus.fifo_count), 32'd0);
    check("post_rst_loc_ready", 32'(bus.loc_ready),  32'd1);
    check("post_rst_starve",    32'(bus.starve),     32'd0);
    check("post_rst_inj_valid", 32'(bus.inj_valid),  32'd0);
    check("post_rst_self",      32'(bus.self_deliver), 32'd0);

    // ---------------- single east injection ----------------
    bus.loc_valid = 1'b1;
    bus.loc_addr  = 6'o57;
    settle();
    check("no_bypass_valid", 32'(bus.inj_valid), 32'd0);
    tick();
    bus.loc_valid = 1'b0;
    settle();
    check("east_count", 32'(bus.fifo_count), 32'd1);
    check("east_valid", 32'(bus.inj_valid),  32'd1);
    check("east_grant", 32'(bus.inj_grant),  32'b0001);
    check("east_flit",  32'(bus.inj_flit),   32'(FLIT_57));
    tick();
    settle();
    check("east_drained", 32'(bus.fifo_count), 32'd0);
    check("east_idle",    32'(bus.inj_valid),  32'd0);
    check("idle_flit",    32'(bus.inj_flit),   32'd0);

    // ---------------- rotation: four south flits from rr_ptr=0 -------------
    do_reset();
    bus.loc_valid = 1'b1;
    bus.loc_addr  = 6'o14;
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) bus.loc_valid = 1'b0;
      settle();
      check($sformatf("rot_valid_%0d", i), 32'(bus.inj_valid), 32'd1);
      check($sformatf("rot_grant_%0d", i), 32'(bus.inj_grant), 32'(4'b0001 << i));
      check($sformatf("rot_flit_%0d", i),  32'(bus.inj_flit),  32'(FLIT_14));
      check($sformatf("rot_count_%0d", i), 32'(bus.fifo_count), 32'd1);
      tick();
    end
    settle();
    check("rot_drained", 32'(bus.fifo_count), 32'd0);

    // ---------------- self delivery (rr_ptr back to 0) ----------------
    bus.loc_valid = 1'b1;
    bus.loc_addr  = 6'o44;
    tick();
    bus.loc_valid = 1'b0;
    bus.ch_busy   = 4'b1111;  // ignored for a local flit
    settle();
    check("self_deliver", 32'(bus.self_deliver), 32'd1);
    check("self_valid",   32'(bus.inj_valid),    32'd0);
    check("self_grant",   32'(bus.inj_grant),    32'd0);
    check("self_flit",    32'(bus.inj_flit),     32'd0);
    check("self_count",   32'(bus.fifo_count),   32'd1);
    tick();
    settle();
    check("self_once",   32'(bus.self_deliver), 32'd0);
    check("self_popped", 32'(bus.fifo_count),   32'd0);

    // ---------------- fill while blocked ----------------
    bus.ch_busy   = 4'b1111;
    bus.loc_valid = 1'b1;
    bus.loc_addr  = 6'o57;
    for (int i = 0; i < 4; i++) begin
      tick();
      settle();
      check($sformatf("fill_count_%0d", i),   32'(bus.fifo_count), 32'(i + 1));
      check($sformatf("fill_blocked_%0d", i), 32'(bus.inj_valid),  32'd0);
    end
    check("full_not_ready", 32'(bus.loc_ready), 32'd0);
    tick();  // loc_valid still high while full: must not be stored
    bus.loc_valid = 1'b0;
    settle();
    check("full_count_held", 32'(bus.fifo_count), 32'd4);
    bus.ch_busy = 4'b1101;
    settle();
    check("release_valid", 32'(bus.inj_valid), 32'd1);
    check("release_grant", 32'(bus.inj_grant), 32'b0010);
    tick();
    bus.ch_busy = 4'b0000;
    settle();
    check("drain_count_3", 32'(bus.fifo_count), 32'd3);
    check("drain_ready",   32'(bus.loc_ready),  32'd1);
    check("drain_grant_0", 32'(bus.inj_grant),  32'b0100);
    tick();
    settle();
    check("drain_grant_1", 32'(bus.inj_grant),  32'b1000);
    tick();
    settle();
    check("drain_grant_2", 32'(bus.inj_grant),  32'b0001);
    tick();
    settle();
    check("drain_empty",   32'(bus.fifo_count), 32'd0);

    // ---------------- starvation (rr_ptr now 1) ----------------
    bus.ch_busy   = 4'b1111;
    bus.loc_valid = 1'b1;
    bus.loc_addr  = 6'o57;
    tick();
    bus.loc_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      settle();
`ifdef INJ_STARVE_EN
      check($sformatf("starve_cycle_%0d", k), 32'(bus.starve), (k >= 16) ? 32'd1 : 32'd0);
`else
      check($sformatf("starve_cycle_%0d", k), 32'(bus.starve), 32'd0);
`endif
      tick();
    end
    bus.ch_busy = 4'b0000;
    settle();
    check("starve_pop_grant", 32'(bus.inj_grant), 32'b0010);
    tick();
    settle();
    check("starve_cleared", 32'(bus.starve),     32'd0);
    check("starve_empty",   32'(bus.fifo_count), 32'd0);

    // ---------------- reset mid-operation (rr_ptr now 2) ----------------
    bus.ch_busy   = 4'b1111;
    bus.loc_valid = 1'b1;
    bus.loc_addr  = 6'o57;
    tick();
    tick();
    bus.loc_valid = 1'b0;
    settle();
    check("pre_flush_count", 32'(bus.fifo_count), 32'd2);
    rst_n       = 1'b0;
    bus.ch_busy = 4'b0000;
    settle();
    check("in_rst_valid", 32'(bus.inj_valid), 32'd0);
    check("in_rst_ready", 32'(bus.loc_ready), 32'd0);
    tick();
    rst_n = 1'b1;
    settle();
    check("flush_count", 32'(bus.fifo_count), 32'd0);
    check("flush_valid", 32'(bus.inj_valid),  32'd0);
    tick();
    settle();
    check("flush_still_idle", 32'(bus.inj_valid), 32'd0);
    bus.loc_valid = 1'b1;
    bus.loc_addr  = 6'o57;
    tick();
    bus.loc_valid = 1'b0;
    settle();
    check("flush_rr_grant", 32'(bus.inj_grant), 32'b0001);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
